// File: rtl/game_step_ctrl_pkg.sv
// Shared board layout and FSM encoding for the auto-walk step controller.
// Board word is {way[63:0], box[63:0], man[5:0]}.
package game_step_ctrl_pkg;

    localparam int BOARD_W    = 134;
    localparam int WAY_LSB    = 70;
    localparam int BOX_LSB    = 6;
    localparam int CELL_W     = 6;
    localparam int DIV_W      = 8;
    localparam int WALK_W     = 6;
    localparam int STEP_CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_WON  = 2'd3
    } state_e;

    function automatic logic box_clear(input logic [BOARD_W-1:0] board);
        return board[WAY_LSB-1:BOX_LSB] == '0;
    endfunction

endpackage

// File: rtl/game_step_ctrl_step_tick.sv
// Step pacing divider: loadable down-counter that flags the cycle in which it
// reaches (or already sits at) zero.
module step_tick
    import game_step_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [DIV_W-1:0] load_val,
    input  logic             dec_en,
    output logic             expire
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_en) begin
            cnt_d = load_val;
        end else if (dec_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Expire on the decrement that lands on zero so a step fires every STEP_DIV cycles.
    assign expire = (cnt_q <= DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_step_ctrl.sv
// Auto-walk controller: owns the current board, paces move-stage steps toward a
// latched cursor, and reports walk completion, failure and the win condition.
module game_step_ctrl
    import game_step_ctrl_pkg::*;
#(
    parameter int STEP_DIV  = 4,
    parameter int MAX_STEPS = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BOARD_W-1:0]      level_state,
    input  logic                    load,
    input  logic [CELL_W-1:0]       cursor,
    input  logic                    walk_req,
    input  logic [BOARD_W-1:0]      mv_state_next,
    input  logic                    mv_ok,
    output logic [BOARD_W-1:0]      game_state,
    output logic [CELL_W-1:0]       mv_cursor,
    output logic                    busy,
    output logic                    walk_done,
    output logic                    walk_fail,
    output logic                    win,
    output logic [STEP_CNT_W-1:0]   step_count
);

    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(STEP_DIV - 1);
    localparam logic [WALK_W-1:0] WALK_MAX   = WALK_W'(MAX_STEPS);

    state_e                  state_q,      state_d;
    logic [BOARD_W-1:0]      game_state_q, game_state_d;
    logic [CELL_W-1:0]       mv_cursor_q,  mv_cursor_d;
    logic [STEP_CNT_W-1:0]   step_count_q, step_count_d;
    logic [WALK_W-1:0]       walk_cnt_q,   walk_cnt_d;
    logic                    busy_q,       busy_d;
    logic                    walk_done_q,  walk_done_d;
    logic                    walk_fail_q,  walk_fail_d;
    logic                    win_q,        win_d;
    logic                    loaded_q,     loaded_d;

    logic                    div_load;
    logic [DIV_W-1:0]        div_load_val;
    logic                    div_dec;
    logic                    div_expire;
    logic                    end_walk;
    logic                    end_fail;

    step_tick u_step_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (div_load),
        .load_val (div_load_val),
        .dec_en   (div_dec),
        .expire   (div_expire)
    );

    always_comb begin
        state_d      = state_q;
        game_state_d = game_state_q;
        mv_cursor_d  = mv_cursor_q;
        step_count_d = step_count_q;
        walk_cnt_d   = walk_cnt_q;
        busy_d       = busy_q;
        loaded_d     = loaded_q;
        walk_done_d  = 1'b0;
        walk_fail_d  = 1'b0;
        win_d        = loaded_q && box_clear(game_state_q);
        div_load     = 1'b0;
        div_load_val = DIV_RELOAD;
        div_dec      = 1'b0;
        end_walk     = 1'b0;
        end_fail     = 1'b0;

        if (load) begin
            // A load silently aborts any walk and outranks a same-cycle commit.
            state_d      = ST_IDLE;
            game_state_d = level_state;
            step_count_d = '0;
            walk_cnt_d   = '0;
            busy_d       = 1'b0;
            loaded_d     = 1'b1;
            win_d        = 1'b0;
            div_load     = 1'b1;
            div_load_val = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (walk_req && loaded_q && !win_q && !box_clear(game_state_q)) begin
                        mv_cursor_d = cursor;
                        walk_cnt_d  = '0;
                        div_load    = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    div_dec = 1'b1;
                    if (div_expire) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (game_state_q[CELL_W-1:0] == mv_cursor_q) begin
                        end_walk = 1'b1;
                    end else if (walk_cnt_q >= WALK_MAX) begin
                        end_walk = 1'b1;
                        end_fail = 1'b1;
                    end else if (mv_ok) begin
                        game_state_d = mv_state_next;
                        step_count_d = (step_count_q == '1) ? step_count_q
                                                            : step_count_q + 1'b1;
                        walk_cnt_d   = walk_cnt_q + 1'b1;
                        div_load     = 1'b1;
                        state_d      = ST_WAIT;
                    end else begin
                        end_walk = 1'b1;
                        end_fail = 1'b1;
                    end
                    if (end_walk) begin
                        busy_d      = 1'b0;
                        walk_done_d = 1'b1;
                        walk_fail_d = end_fail;
                        state_d     = box_clear(game_state_q) ? ST_WON : ST_IDLE;
                    end
                end
                ST_WON: begin
                    state_d = ST_WON;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            game_state_q <= '0;
            mv_cursor_q  <= '0;
            step_count_q <= '0;
            walk_cnt_q   <= '0;
            busy_q       <= 1'b0;
            walk_done_q  <= 1'b0;
            walk_fail_q  <= 1'b0;
            win_q        <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_state_q <= game_state_d;
            mv_cursor_q  <= mv_cursor_d;
            step_count_q <= step_count_d;
            walk_cnt_q   <= walk_cnt_d;
            busy_q       <= busy_d;
            walk_done_q  <= walk_done_d;
            walk_fail_q  <= walk_fail_d;
            win_q        <= win_d;
            loaded_q     <= loaded_d;
        end
    end

    assign game_state = game_state_q;
    assign mv_cursor  = mv_cursor_q;
    assign busy       = busy_q;
    assign walk_done  = walk_done_q;
    assign walk_fail  = walk_fail_q;
    assign win        = win_q;
    assign step_count = step_count_q;

endmodule

// File: doc/game_step_ctrl.md
GAME_STEP_CTRL -- requirements
Module: game_step_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 4, SHALL set the clock cycles between successive auto-walk steps (range 1..255).
REQ-002 Parameter MAX_STEPS, default 14, SHALL set the step limit per walk request (range 1..63).
REQ-003 Port clk, input, 1, SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port level_state, input, 134, SHALL be the initial board {way[63:0], box[63:0], man[5:0]} for a level load.
REQ-006 Port load, input, 1, SHALL be a single-cycle pulse that loads level_state.
REQ-007 Port cursor, input, 6, SHALL be the target cell {y[2:0], x[2:0]}, sampled with walk_req.
REQ-008 Port walk_req, input, 1, SHALL be a single-cycle pulse requesting a walk to cursor.
REQ-009 Port mv_state_next, input, 134, SHALL be the combinational next board returned by the move stage.
REQ-010 Port mv_ok, input, 1, SHALL be the move stage's success flag for the current game_state and mv_cursor.
REQ-011 Port game_state, output, 134, SHALL be the registered current board, driving both the move stage and display.
REQ-012 Port mv_cursor, output, 6, SHALL be the latched walk target driving the move stage.
REQ-013 Port busy, output, 1, SHALL be high while a walk is in progress.
REQ-014 Port walk_done, output, 1, SHALL pulse one cycle when a walk ends; walk_fail SHALL pulse in the same cycle if it ended blocked or at MAX_STEPS.
REQ-015 Port win, output, 1, SHALL be high while box[63:0] of game_state is all zero after a load.
REQ-016 Port step_count, output, 10, SHALL be the number of accepted steps since the last load, saturating at 1023.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, STEP, WON.
REQ-018 IDLE: on walk_req with win low, the block SHALL latch cursor into mv_cursor, clear the per-walk step counter, load the divider with STEP_DIV-1, and go to WAIT; walk_req SHALL be ignored in all other states.
REQ-019 WAIT: the divider SHALL decrement each cycle and the FSM SHALL enter STEP when it reaches 0.
REQ-020 STEP (one cycle): if game_state[5:0]==mv_cursor, the block SHALL end the walk with success.
REQ-021 STEP: else if mv_ok=1, the block SHALL register mv_state_next into game_state, increment step_count and the per-walk counter, reload the divider, and return to WAIT.
REQ-022 STEP: else the block SHALL end the walk with walk_fail.
REQ-023 The block SHALL end the walk with walk_fail once the per-walk counter reaches MAX_STEPS, without sampling mv_ok.
REQ-024 On walk end, the FSM SHALL go to WON if box==0 in the updated state, otherwise to IDLE; busy SHALL drop in the walk_done cycle.
REQ-025 WON: the block SHALL hold game_state and ignore walk_req until load.
REQ-026 load in any state SHALL overwrite game_state with level_state, clear step_count, abort any walk without a walk_done pulse, and go to IDLE; load SHALL have priority over a simultaneous STEP commit.
REQ-027 win SHALL be registered, evaluated from the stored game_state, and valid one cycle after each update.
REQ-028 game_state SHALL change only on load or an accepted STEP, never combinationally from inputs.

Reset
REQ-029 On rst_n low the block SHALL immediately set FSM=IDLE, game_state=0, mv_cursor=0, step_count=0, divider=0, per-walk counter=0, and busy=walk_done=walk_fail=win=0.
REQ-030 After reset, the block SHALL require a load before walk_req; walk_req before the first load SHALL be ignored (win low, board empty, mv_ok=0 results in an immediate fail).

Structure
REQ-031 A shared game package SHALL hold the board width (134), field offsets (WAY_LSB=70, BOX_LSB=6), cell width 6, and the FSM state encoding.
REQ-032 The timing divider SHALL be a sub-module step_tick (load value, decrement, zero flag); the move stage SHALL be instantiated outside this block.

Verification
REQ-033 Load a board with man=6'o11 and a clear path; walk_req with cursor=6'o14 -> 3 steps STEP_DIV apart, man=6'o14, step_count=3, walk_done=1, walk_fail=0.
REQ-034 Walk into a wall: mv_ok forced 0 -> walk_done and walk_fail pulse together after STEP_DIV cycles, game_state unchanged, step_count unchanged.
REQ-035 Final step clears the last box bit -> FSM enters WON with win=1, a later walk_req is ignored, and load returns the FSM to IDLE with win=0 and step_count=0.
REQ-036 MAX_STEPS=2 with an oscillating mv_ok=1 path never reaching the cursor -> walk_fail after 2 accepted steps.
REQ-037 Assert load in the same cycle as an accepted STEP -> game_state=level_state, no walk_done pulse, busy=0.
REQ-038 Assert rst_n low mid-WAIT -> all outputs are 0 immediately with no clock edge, and the FSM is in IDLE after release.
